// File: rtl/qpsk_pkg.sv
// Shared constants for the QPSK receive path: widths, reference tables, dibit codes, FSM states.
package qpsk_pkg;

    localparam int unsigned SPS      = 16;
    localparam int unsigned SAMPLE_W = 10;
    localparam int unsigned LUT_W    = 8;
    localparam int unsigned K_W      = $clog2(SPS);
    localparam int unsigned PROD_W   = SAMPLE_W + LUT_W;
    localparam int unsigned ACC_W    = SAMPLE_W + LUT_W + K_W;

    localparam logic [1:0] DIBIT_00 = 2'b00;
    localparam logic [1:0] DIBIT_01 = 2'b01;
    localparam logic [1:0] DIBIT_11 = 2'b11;
    localparam logic [1:0] DIBIT_10 = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // round(127*cos(2*pi*k/16)) and round(127*sin(2*pi*k/16))
    localparam logic signed [LUT_W-1:0] COS_LUT [SPS] = '{
        8'sd127,  8'sd117,  8'sd90,   8'sd49,   8'sd0,    -8'sd49,  -8'sd90,  -8'sd117,
        -8'sd127, -8'sd117, -8'sd90,  -8'sd49,  8'sd0,    8'sd49,   8'sd90,   8'sd117
    };

    localparam logic signed [LUT_W-1:0] SIN_LUT [SPS] = '{
        8'sd0,    8'sd49,   8'sd90,   8'sd117,  8'sd127,  8'sd117,  8'sd90,   8'sd49,
        8'sd0,    -8'sd49,  -8'sd90,  -8'sd117, -8'sd127, -8'sd117, -8'sd90,  -8'sd49
    };

endpackage

// File: rtl/qpsk_correlator.sv
// One correlator arm: registered sample*reference product feeding a symbol accumulator.
module qpsk_correlator
    import qpsk_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       mul_en,
    input  logic                       acc_en,
    input  logic                       acc_load,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic signed [LUT_W-1:0]    ref_val,
    output logic                       acc_neg
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;

    // acc_load starts a new symbol from the first product instead of adding to the old sum
    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            if (mul_en) begin
                prod <= PROD_W'(sample) * PROD_W'(ref_val);
            end
            if (clr) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc_load ? ACC_W'(prod) : acc + ACC_W'(prod);
            end
        end
    end

    assign acc_neg = acc[ACC_W-1];

endmodule

// File: rtl/qpsk_demodulate.sv
// QPSK receiver: phase counter, symbol-sync FSM, two correlator arms, dibit decision and handshake.
module qpsk_demodulate
    import qpsk_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       sym_sync,
    output logic                       Ichannel,
    output logic                       Qchannel,
    output logic                       bit_valid,
    input  logic                       bit_ready,
    output logic                       overrun,
    output logic                       locked
);

    state_t             state_q;
    state_t             state_d;
    logic [K_W-1:0]     k_q;
    logic [K_W-1:0]     idx_c;
    logic               take_c;
    logic               resync_c;
    logic               v1_q;
    logic               first1_q;
    logic               last1_q;
    logic               v2_q;
    logic signed [LUT_W-1:0] i_ref_c;
    logic signed [LUT_W-1:0] q_ref_c;
    logic               i_neg;
    logic               q_neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sym_sync) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // A sync away from a symbol boundary restarts the symbol; at k=0 it changes nothing
    always_comb begin
        take_c   = 1'b0;
        resync_c = 1'b0;
        idx_c    = '0;
        if (state_q == RUN) begin
            take_c   = sample_valid;
            resync_c = sym_sync && (k_q != '0);
            idx_c    = sym_sync ? '0 : k_q;
        end else begin
            take_c   = sample_valid && sym_sync;
        end
    end

    assign i_ref_c = COS_LUT[idx_c];
    assign q_ref_c = -SIN_LUT[idx_c];

    qpsk_correlator u_corr_i (
        .clk      (clk),
        .rst      (rst),
        .clr      (resync_c),
        .mul_en   (take_c),
        .acc_en   (v1_q),
        .acc_load (first1_q),
        .sample   (sample_in),
        .ref_val  (i_ref_c),
        .acc_neg  (i_neg)
    );

    qpsk_correlator u_corr_q (
        .clk      (clk),
        .rst      (rst),
        .clr      (resync_c),
        .mul_en   (take_c),
        .acc_en   (v1_q),
        .acc_load (first1_q),
        .sample   (sample_in),
        .ref_val  (q_ref_c),
        .acc_neg  (q_neg)
    );

    // Phase counter, pipeline tags, decision register and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q       <= '0;
            v1_q      <= 1'b0;
            first1_q  <= 1'b0;
            last1_q   <= 1'b0;
            v2_q      <= 1'b0;
            Ichannel  <= 1'b0;
            Qchannel  <= 1'b0;
            bit_valid <= 1'b0;
            overrun   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            locked <= (state_d == RUN);

            if (take_c) begin
                k_q <= idx_c + K_W'(1);
            end else if (resync_c) begin
                k_q <= '0;
            end

            v1_q     <= take_c;
            first1_q <= (idx_c == '0);
            last1_q  <= (idx_c == K_W'(SPS - 1));
            v2_q     <= v1_q && last1_q && !resync_c;

            if (v2_q) begin
                Ichannel  <= ~i_neg;
                Qchannel  <= ~q_neg;
                bit_valid <= 1'b1;
                if (bit_valid && !bit_ready) begin
                    overrun <= 1'b1;
                end
            end else if (bit_valid && bit_ready) begin
                bit_valid <= 1'b0;
            end
        end
    end

endmodule
